// File: rtl/cayde_core_mc.sv
// cayde_core_mc: multi-cycle RV32I/RV64I integer core (OP and OP-IMM).
// Each instruction is fetched over a req/ack handshake. It then steps through
// DECODE, EXEC and WB, so one instruction takes four cycles plus imem wait cycles.
// Any instruction the core does not support parks it in HALT until reset.
//
// Optional feature macro: CAYDE_BRANCH_EN
//   defined   -> conditional branches (opcode 0x63) are executed
//   undefined -> opcode 0x63 is illegal and halts the core
//
// Parameters: XLEN (32/64), PC_W (PC width, wraps), NREG (32 or 16), RESET_PC
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   imem_req    fetch request, held until imem_ack is sampled
//   imem_addr   fetch byte address (the PC)
//   imem_ack    fetch data valid
//   imem_rdata  instruction word
//   opcode      instr[6:0] of the latched instruction
//   funct7      instr[31:25] of the latched instruction
//   funct3      instr[14:12] of the latched instruction
//   alu_output  result of the most recent EXEC
//   retire      one-cycle pulse per completed instruction
//   halted      sticky illegal-instruction flag
module cayde_core_mc #(
    parameter int              XLEN     = 32,
    parameter int              PC_W     = 9,
    parameter int              NREG     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [6:0]      opcode,
    output logic [6:0]      funct7,
    output logic [2:0]      funct3,
    output logic [XLEN-1:0] alu_output,
    output logic            retire,
    output logic            halted
);
    localparam int         RIDX     = $clog2(NREG);
    localparam int         SHW      = $clog2(XLEN);
    localparam logic [5:0] NREG_LIM = 6'(NREG);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic              retire_q, retire_d;
    logic              halted_q, halted_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];

    logic [4:0]        rd, rs1, rs2;
    logic              rd_ok, rs1_ok, rs2_ok;
    logic              is_op, is_op_imm, is_branch;
    logic              legal;
    logic [6:0]        shift_f7;
    logic [XLEN-1:0]   imm_sext, rs1_val, rs2_val;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_result;
    logic [PC_W-1:0]   next_pc;

    assign opcode     = instr_q[6:0];
    assign funct7     = instr_q[31:25];
    assign funct3     = instr_q[14:12];
    assign alu_output = alu_q;
    assign retire     = retire_q;
    assign halted     = halted_q;
    assign imem_req   = req_q;
    assign imem_addr  = pc_q;

    assign rd  = instr_q[11:7];
    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];

    assign rd_ok  = {1'b0, rd}  < NREG_LIM;
    assign rs1_ok = {1'b0, rs1} < NREG_LIM;
    assign rs2_ok = {1'b0, rs2} < NREG_LIM;

    assign is_op     = opcode == 7'h33;
    assign is_op_imm = opcode == 7'h13;
`ifdef CAYDE_BRANCH_EN
    assign is_branch = opcode == 7'h63;
`else
    assign is_branch = 1'b0;
`endif

    assign imm_sext = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1[RIDX-1:0]];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2[RIDX-1:0]];

    // On RV64 the shift amount takes 6 bits, so bit 25 belongs to shamt
    // and only instr[31:26] carries the SRLI/SRAI selector.
    assign shift_f7 = (XLEN == 64) ? {instr_q[31:26], 1'b0} : instr_q[31:25];

    always_comb begin
        legal = 1'b0;
        if (is_op) begin
            legal = (funct7 == 7'h00 ||
                     (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    && rs1_ok && rs2_ok && rd_ok;
        end else if (is_op_imm) begin
            case (funct3)
                3'b001:  legal = shift_f7 == 7'h00;
                3'b101:  legal = shift_f7 == 7'h00 || shift_f7 == 7'h20;
                default: legal = 1'b1;
            endcase
            legal = legal && rs1_ok && rd_ok;
        end
`ifdef CAYDE_BRANCH_EN
        else if (is_branch) begin
            legal = funct3 != 3'b010 && funct3 != 3'b011 && rs1_ok && rs2_ok;
        end
`endif
    end

    // op_b_q already holds either rs2 or the sign-extended immediate, so the
    // R- and I-forms share the same ALU; only register SUB uses funct7[5] on 000.
    always_comb begin
        shamt      = op_b_q[SHW-1:0];
        alu_result = '0;
        case (funct3)
            3'b000:  alu_result = (is_op && funct7[5]) ? op_a_q - op_b_q : op_a_q + op_b_q;
            3'b001:  alu_result = op_a_q << shamt;
            3'b010:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a_q) < $signed(op_b_q)};
            3'b011:  alu_result = {{(XLEN-1){1'b0}}, op_a_q < op_b_q};
            3'b100:  alu_result = op_a_q ^ op_b_q;
            3'b101:  alu_result = funct7[5] ? XLEN'($signed(op_a_q) >>> shamt) : op_a_q >> shamt;
            3'b110:  alu_result = op_a_q | op_b_q;
            default: alu_result = op_a_q & op_b_q;
        endcase
`ifdef CAYDE_BRANCH_EN
        if (is_branch) begin
            case (funct3)
                3'b000:  alu_result = {{(XLEN-1){1'b0}}, op_a_q == op_b_q};
                3'b001:  alu_result = {{(XLEN-1){1'b0}}, op_a_q != op_b_q};
                3'b100:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a_q) < $signed(op_b_q)};
                3'b101:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a_q) >= $signed(op_b_q)};
                3'b110:  alu_result = {{(XLEN-1){1'b0}}, op_a_q < op_b_q};
                default: alu_result = {{(XLEN-1){1'b0}}, op_a_q >= op_b_q};
            endcase
        end
`endif
    end

`ifdef CAYDE_BRANCH_EN
    logic [12:0] b_imm;
    assign b_imm   = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    // alu_q[0] carries the branch decision latched in EXEC.
    assign next_pc = (is_branch && alu_q[0]) ? pc_q + PC_W'($signed(b_imm))
                                             : pc_q + PC_W'(4);
`else
    assign next_pc = pc_q + PC_W'(4);
`endif

    // imem_req is registered: it rises one cycle after reset, and WB raises it
    // again on the way back into FETCH. This is why a zero-wait fetch costs one cycle.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        alu_d    = alu_q;
        retire_d = 1'b0;
        halted_d = halted_q;
        req_d    = req_q;
        regs_d   = regs_q;
        case (state_q)
            FETCH: begin
                req_d = 1'b1;
                if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                op_a_d = rs1_val;
                op_b_d = is_op_imm ? imm_sext : rs2_val;
                if (legal) begin
                    state_d = EXEC;
                end else begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end
            end
            EXEC: begin
                alu_d    = alu_result;
                retire_d = 1'b1;
                state_d  = WB;
            end
            WB: begin
                if (!is_branch && rd != 5'd0) begin
                    regs_d[rd[RIDX-1:0]] = alu_q;
                end
                pc_d    = next_pc;
                req_d   = 1'b1;
                state_d = FETCH;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            alu_q    <= '0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            req_q    <= 1'b0;
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            alu_q    <= alu_d;
            retire_q <= retire_d;
            halted_q <= halted_d;
            req_q    <= req_d;
            regs_q   <= regs_d;
        end
    end

endmodule

// File: doc/cayde_core_mc.md
Name: cayde_core_mc

Overview:
Parametrised multi-cycle successor to the single-cycle cayde top.
- Fetches through a req/ack instruction-memory handshake instead of a combinational ROM.
- Sequences FETCH/DECODE/EXEC/WB with an internal FSM; contains its own register file and ALU.
- Executes RV32I OP and OP-IMM integer instructions; anything else halts the core.
- Still exports opcode/funct fields and the ALU result for debug visibility.

Parameters:
- XLEN, 32, datapath and register width (32 or 64).
- PC_W, 9, PC width in bits; PC arithmetic wraps modulo 2^PC_W.
- NREG, 32, architectural registers (32, or 16 for E-profile).
- RESET_PC, 0, PC value loaded on reset (must be word aligned).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low (core in reset while 0)
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch byte address (= PC)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  instruction word
- opcode  out  7  instr[6:0] of the latched instruction
- funct7  out  7  instr[31:25] of the latched instruction
- funct3  out  3  instr[14:12] of the latched instruction
- alu_output  out  XLEN  last EXEC result
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  sticky illegal-instruction halt

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, PC=RESET_PC.
  - Outputs reset to: instr latch=0 (so opcode/funct7/funct3=0), alu_output=0, retire=0, halted=0, imem_req=0.
  - All registers=0.
  - Reset asserted mid-handshake abandons the fetch; no write is committed.
- FSM states: FETCH, DECODE, EXEC, WB, HALT.
- FETCH:
  - imem_req=1 with imem_addr=PC, held stable until imem_ack=1 is sampled.
  - On that edge: latch imem_rdata into instr, go to DECODE.
  - Same-cycle ack is allowed (minimum 1 cycle).
  - imem_ack while imem_req=0 is ignored.
- DECODE:
  - Read rs1 and rs2, latch operands, sign-extend imm[11:0].
  - Check legality. Legal = opcode 0x33 or 0x13 with a defined funct3/funct7 combination, and every used register index < NREG.
  - Illegal -> HALT, halted=1. No register write, PC unchanged.
  - Legal -> EXEC.
- EXEC:
  - Operations: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, plus the I-forms (SUB has no I-form).
  - Shift amount = low log2(XLEN) bits of rs2 or imm; SRAI/SRLI are selected by funct7[5].
  - Result is latched into alu_output. Go to WB.
- WB:
  - If rd != 0, write the result to rd.
  - PC <= PC+4 (mod 2^PC_W).
  - retire=1 for exactly this cycle. Go to FETCH.
- Register x0 reads 0 always; writes to it are discarded.
- Register read and write never overlap (multi-cycle), so no bypass is needed.
- Throughput: one instruction per 4 cycles plus imem wait cycles.
- HALT: sticky until reset. imem_req=0, retire=0; all outputs hold their values.
- PC wrap: PC=2^PC_W-4 followed by retire gives PC=0.

Optional Feature:
Macro CAYDE_BRANCH_EN.
- Defined:
  - Opcode 0x63 with funct3 BEQ/BNE/BLT/BGE/BLTU/BGEU is legal.
  - EXEC evaluates the condition.
  - WB sets PC to PC+B-imm (mod 2^PC_W) if taken, else PC+4.
  - No register write; retire pulses; alu_output = comparison result (0/1).
- Undefined: opcode 0x63 is illegal and the core halts.

Test Plan:
- Ack latency: rst low->high, imem_ack delayed 3 cycles after req -> imem_addr holds 0 throughout; instr captured only on the ack edge; first retire 3 cycles later than with zero-wait ack.
- Add/sub sequence: fetch 0x00500093 (ADDI x1,x0,5), 0xFFD00113 (ADDI x2,x0,-3), 0x002081B3 (ADD x3,x1,x2), 0x40208233 (SUB x4,x1,x2) -> alu_output = 5, 0xFFFFFFFD, 2, 8; PC = 0x10 after 4 retires.
- x0 write: 0x00700013 (ADDI x0,x0,7) -> alu_output=7; a following ADD x3,x0,x0 gives 0.
- Arithmetic shift: x2=-3, then 0x40115293 (SRAI x5,x2,1) -> alu_output=0xFFFFFFFE.
- Illegal instruction: 0x00000000 at PC=0x8 -> halted=1; no further imem_req; PC stays 0x8. Asserting rst clears halted and PC=0.
- Branch with CAYDE_BRANCH_EN: 0x00108463 (BEQ x1,x1,+8) at PC=0x10 -> next imem_addr=0x18. Without the macro -> halted=1.
